sprite_engine: RTL and testbench

//  Per-line sprite pixel generator directly downstream of sprite_check.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_check_if.sv | 33 +++
 rtl/sprite_slot.sv | 42 ++++
 rtl/sprite_engine.sv | 128 ++++++++++++
 tb/tb_sprite_engine.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel pipeline.
// Slot record layout, request FSM states and sprite geometry.
package sprite_pkg;

    localparam int SPR_W  = 16;
    localparam int SPR_PX = 16;
    localparam int COL_W  = 10;

    typedef struct packed {
        logic                      valid;
        logic [COL_W-1:0]          cnt;
        logic [4:0]                rem;
        logic [SPR_W*SPR_PX-1:0]   shreg;
        logic [1:0]                prio;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } req_state_t;

endpackage

// File: rtl/sprite_check_if.sv
// Bundle between sprite_check (slave) and sprite_engine (master).
// Ports: check_start/check_ready handshake plus the per-slot line arrays.
interface sprite_check_if #(
    parameter int N = 8
);
    import sprite_pkg::*;

    logic                              check_start;
    logic                              check_ready;
    logic [N-1:0]                      slot_valid;
    logic [N-1:0][COL_W-1:0]           slot_counter_init;
    logic [N-1:0][SPR_W*SPR_PX-1:0]    slot_pixel_row;
    logic [N-1:0][1:0]                 slot_priority;

    modport master (
        output check_start,
        input  check_ready,
        input  slot_valid,
        input  slot_counter_init,
        input  slot_pixel_row,
        input  slot_priority
    );

    modport slave (
        input  check_start,
        output check_ready,
        output slot_valid,
        output slot_counter_init,
        output slot_pixel_row,
        output slot_priority
    );

endinterface

// File: rtl/sprite_slot.sv
// One active sprite slot: start-column down-counter and pixel shifter.
// Ports: clk/reset, load_i (line_start), adv_i (pix_en), ld_i, live_o/color_o/prio_o.
module sprite_slot
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             adv_i,
    input  slot_t            ld_i,
    output logic             live_o,
    output logic [SPR_W-1:0] color_o,
    output logic [1:0]       prio_o
);

    slot_t s_q, s_d;

    always_comb begin
        s_d = s_q;
        if (load_i) begin
            s_d = ld_i;
        end else if (adv_i) begin
            // Count down to the start column, then emit one pixel per strobe.
            if (s_q.cnt != '0) begin
                s_d.cnt = s_q.cnt - 1'b1;
            end else if (s_q.rem != '0) begin
                s_d.shreg = s_q.shreg >> SPR_W;
                s_d.rem   = s_q.rem - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) s_q <= '0;
        else       s_q <= s_d;
    end

    assign live_o  = s_q.valid && (s_q.cnt == '0) && (s_q.rem != '0);
    assign color_o = s_q.shreg[SPR_W-1:0];
    assign prio_o  = s_q.prio;

endmodule

// File: rtl/sprite_engine.sv
// Per-line sprite pixel generator: fetches slots in hblank into a shadow
// bank, promotes it at line_start and muxes the winning opaque pixel.
// Ports: clk, reset, hblank_start, line_start, pix_en, chk (master),
//        spr_valid/spr_color/spr_priority, line_overrun.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int               MAX_ACTIVE  = 8,
    parameter logic [SPR_W-1:0] TRANSPARENT = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hblank_start,
    input  logic                  line_start,
    input  logic                  pix_en,
    sprite_check_if.master        chk,
    output logic                  spr_valid,
    output logic [SPR_W-1:0]      spr_color,
    output logic [1:0]            spr_priority,
    output logic                  line_overrun
);

    req_state_t state_q, state_d;
    logic       pending_q, pending_d;
    logic       shadow_full_q;
    logic       overrun_q;
    logic       capture;
    logic       start;

    slot_t [MAX_ACTIVE-1:0] shadow_q;

    logic [MAX_ACTIVE-1:0]             live;
    logic [MAX_ACTIVE-1:0][SPR_W-1:0]  color;
    logic [MAX_ACTIVE-1:0][1:0]        prio;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        capture   = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hblank_start) state_d = WAIT;
            end
            WAIT: begin
                start = 1'b1;
                if (chk.check_ready) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Wait for ready to drop so one start never spans two captures.
                if (!chk.check_ready) begin
                    state_d   = (pending_q || hblank_start) ? WAIT : IDLE;
                    pending_d = 1'b0;
                end else if (hblank_start) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign chk.check_start = start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            shadow_full_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            // A capture coinciding with line_start refills the shadow.
            shadow_full_q <= capture | (shadow_full_q & ~line_start);
            overrun_q     <= line_start & ~shadow_full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < MAX_ACTIVE; i++) begin
                shadow_q[i].valid <= chk.slot_valid[i];
                shadow_q[i].cnt   <= chk.slot_counter_init[i];
                shadow_q[i].rem   <= 5'(SPR_PX);
                shadow_q[i].shreg <= chk.slot_pixel_row[i];
                shadow_q[i].prio  <= chk.slot_priority[i];
            end
        end
    end

    for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
        slot_t ld;
        always_comb begin
            ld       = shadow_q[g];
            ld.valid = shadow_full_q & shadow_q[g].valid;
        end
        sprite_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .load_i  (line_start),
            .adv_i   (pix_en),
            .ld_i    (ld),
            .live_o  (live[g]),
            .color_o (color[g]),
            .prio_o  (prio[g])
        );
    end

    // Scan high to low so the lowest-index opaque slot wins.
    always_comb begin
        spr_valid    = 1'b0;
        spr_color    = '0;
        spr_priority = '0;
        for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
            if (live[i] && (color[i] != TRANSPARENT)) begin
                spr_valid    = 1'b1;
                spr_color    = color[i];
                spr_priority = prio[i];
            end
        end
    end

    assign line_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine against a column-level model.
// Drives the sprite_check side of the interface directly.
module tb_sprite_engine;
    import sprite_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        hblank_start;
    logic        line_start;
    logic        pix_en;
    logic        spr_valid;
    logic [15:0] spr_color;
    logic [1:0]  spr_priority;
    logic        line_overrun;

    sprite_check_if #(.N(N)) chk();

    sprite_engine #(.MAX_ACTIVE(N), .TRANSPARENT(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .hblank_start (hblank_start),
        .line_start   (line_start),
        .pix_en       (pix_en),
        .chk          (chk),
        .spr_valid    (spr_valid),
        .spr_color    (spr_color),
        .spr_priority (spr_priority),
        .line_overrun (line_overrun)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Stimulus bank presented by the fake sprite_check.
    bit          in_v  [N];
    int          in_col[N];
    logic [15:0] in_px [N][16];
    logic [1:0]  in_p  [N];
    // Model shadow and active banks.
    bit          sh_v  [N];
    int          sh_col[N];
    logic [15:0] sh_px [N][16];
    logic [1:0]  sh_p  [N];
    bit          ac_v  [N];
    int          ac_col[N];
    logic [15:0] ac_px [N][16];
    logic [1:0]  ac_p  [N];
    bit          sh_full = 0;
    bit          ovr_exp = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bank();
        for (int i = 0; i < N; i++) begin
            in_v[i] = 0;
            in_col[i] = 0;
            in_p[i] = 0;
            for (int k = 0; k < 16; k++) in_px[i][k] = 16'h0;
        end
    endtask

    task automatic rand_bank(int maxcol);
        for (int i = 0; i < N; i++) begin
            in_v[i]   = ($urandom_range(0, 2) != 0);
            in_col[i] = $urandom_range(0, maxcol);
            in_p[i]   = 2'($urandom_range(0, 3));
            for (int k = 0; k < 16; k++)
                in_px[i][k] = ($urandom_range(0, 3) == 0) ? 16'h0
                                                           : 16'($urandom);
        end
    endtask

    task automatic drive_bank();
        for (int i = 0; i < N; i++) begin
            chk.slot_valid[i]        = in_v[i];
            chk.slot_counter_init[i] = 10'(in_col[i]);
            chk.slot_priority[i]     = in_p[i];
            for (int k = 0; k < 16; k++)
                chk.slot_pixel_row[i][16*k +: 16] = in_px[i][k];
        end
    endtask

    task automatic model_capture();
        sh_v = in_v; sh_col = in_col; sh_px = in_px; sh_p = in_p;
        sh_full = 1;
    endtask

    task automatic model_line();
        ovr_exp = !sh_full;
        if (sh_full) begin
            ac_v = sh_v; ac_col = sh_col; ac_px = sh_px; ac_p = sh_p;
        end else begin
            for (int i = 0; i < N; i++) ac_v[i] = 0;
        end
        sh_full = 0;
    endtask

    task automatic expect_at(input int x, output logic ev,
                             output logic [15:0] ec, output logic [1:0] ep);
        ev = 0; ec = 0; ep = 0;
        for (int i = 0; i < N; i++) begin
            if (!ev && ac_v[i] && x >= ac_col[i] && x < ac_col[i] + 16
                && ac_px[i][x - ac_col[i]] != 16'h0) begin
                ev = 1;
                ec = ac_px[i][x - ac_col[i]];
                ep = ac_p[i];
            end
        end
    endtask

    task automatic check_pix(input int x, input string tag);
        logic ev;
        logic [15:0] ec;
        logic [1:0] ep;
        expect_at(x, ev, ec, ep);
        n_run++;
        if ({spr_valid, spr_color, spr_priority} !== {ev, ec, ep}) begin
            n_fail++;
            $display("FAIL %s x=%0d got v=%b c=%h p=%0d expected v=%b c=%h p=%0d",
                     tag, x, spr_valid, spr_color, spr_priority, ev, ec, ep);
        end
    endtask

    task automatic check_cs(input logic exp, input string tag);
        n_run++;
        if (chk.check_start !== exp) begin
            n_fail++;
            $display("FAIL %s check_start got %b expected %b",
                     tag, chk.check_start, exp);
        end
    endtask

    task automatic wait_cs(input string tag);
        int t = 0;
        while (chk.check_start !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        check_cs(1'b1, tag);
    endtask

    task automatic do_capture(input string tag);
        hblank_start = 1; tick(); hblank_start = 0;
        wait_cs(tag);
        drive_bank();
        chk.check_ready = 1; tick(); model_capture();
        chk.check_ready = 0; tick();
    endtask

    task automatic do_line(input string tag);
        line_start = 1; tick(); line_start = 0;
        model_line();
        n_run++;
        if (line_overrun !== ovr_exp) begin
            n_fail++;
            $display("FAIL %s line_overrun got %b expected %b",
                     tag, line_overrun, ovr_exp);
        end
    endtask

    task automatic scan(input int ncols, input bit gaps, input string tag);
        for (int x = 0; x <= ncols; x++) begin
            check_pix(x, tag);
            if (gaps && $urandom_range(0, 2) == 0) begin
                tick();
                check_pix(x, tag);
            end
            pix_en = 1; tick(); pix_en = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1; hblank_start = 0; line_start = 0; pix_en = 0;
        chk.check_ready = 0;
        clear_bank(); drive_bank();
        tick(); tick(); tick();
        check_cs(1'b0, "reset_cs");
        n_run++;
        if (spr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b expected 0", spr_valid);
        end
        n_run++;
        if (spr_color !== 16'h0 || spr_priority !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_pix got c=%h p=%0d expected 0", spr_color, spr_priority);
        end
        n_run++;
        if (line_overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovr got %b expected 0", line_overrun);
        end
        reset = 0; tick();
    endtask

    task automatic test_single();
        clear_bank();
        in_v[0] = 1; in_col[0] = 5; in_p[0] = 2'd2;
        for (int k = 0; k < 16; k++) in_px[0][k] = 16'h0101 + 16'(k);
        do_capture("single_cap");
        do_line("single_line");
        scan(30, 0, "single");
    endtask

    task automatic test_overlap();
        clear_bank();
        in_v[0] = 1; in_col[0] = 10; in_p[0] = 2'd1;
        for (int k = 0; k < 16; k++) in_px[0][k] = 16'h1000 + 16'(k);
        in_px[0][2] = 16'h0;
        in_v[1] = 1; in_col[1] = 8; in_p[1] = 2'd3;
        for (int k = 0; k < 16; k++) in_px[1][k] = 16'hBEEF;
        do_capture("overlap_cap");
        do_line("overlap_line");
        scan(30, 0, "overlap");
    endtask

    task automatic test_random();
        for (int l = 0; l < 4; l++) begin
            rand_bank(48);
            do_capture("rand_cap");
            do_line("rand_line");
            scan(70, 1, "random");
        end
    endtask

    task automatic test_overrun();
        hblank_start = 1; tick(); hblank_start = 0;
        wait_cs("ovr_wait");
        do_line("ovr_line");
        tick();
        n_run++;
        if (line_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ovr_pulse got %b expected 0", line_overrun);
        end
        scan(30, 0, "ovr_blank");
        rand_bank(20); drive_bank();
        chk.check_ready = 1; tick(); model_capture();
        chk.check_ready = 0; tick();
        do_line("ovr_recover");
        scan(40, 0, "ovr_recover");
    endtask

    task automatic test_pending();
        rand_bank(30);
        hblank_start = 1; tick(); hblank_start = 0;
        wait_cs("pend_wait");
        drive_bank();
        chk.check_ready = 1; tick(); model_capture();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) hblank_start = 1;
            tick();
            hblank_start = 0;
            check_cs(1'b0, "pend_hold");
        end
        chk.check_ready = 0; tick();
        check_cs(1'b1, "pend_rise");
        rand_bank(30); drive_bank();
        chk.check_ready = 1; tick(); model_capture();
        chk.check_ready = 0; tick();
        check_cs(1'b0, "pend_done");
        tick();
        check_cs(1'b0, "pend_idle");
        do_line("pend_line");
        scan(50, 0, "pend_pix");
    endtask

    task automatic test_same_clk();
        rand_bank(40);
        do_capture("same_capA");
        hblank_start = 1; tick(); hblank_start = 0;
        wait_cs("same_wait");
        rand_bank(40); drive_bank();
        chk.check_ready = 1; line_start = 1; tick();
        model_line(); model_capture();
        chk.check_ready = 0; line_start = 0;
        n_run++;
        if (line_overrun !== 1'b0) begin
            n_fail++; $display("FAIL same_ovr got %b expected 0", line_overrun);
        end
        scan(60, 0, "same_old");
        do_line("same_next");
        scan(60, 0, "same_new");
    endtask

    task automatic test_reset_mid();
        clear_bank();
        in_v[0] = 1; in_col[0] = 3; in_p[0] = 2'd1;
        for (int k = 0; k < 16; k++) in_px[0][k] = 16'h0A00 + 16'(k);
        do_capture("rmid_cap");
        do_line("rmid_line");
        hblank_start = 1; tick(); hblank_start = 0;
        for (int x = 0; x < 7; x++) begin
            pix_en = 1; tick(); pix_en = 0;
        end
        check_pix(7, "rmid_before");
        check_cs(1'b1, "rmid_cs_before");
        reset = 1; tick(); reset = 0;
        sh_full = 0;
        for (int i = 0; i < N; i++) ac_v[i] = 0;
        check_pix(7, "rmid_after");
        check_cs(1'b0, "rmid_cs_after");
        tick();
        do_line("rmid_ovr");
        scan(20, 0, "rmid_blank");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_random();
        test_overrun();
        test_pending();
        test_same_clk();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
